// File: rtl/pvt_gpi_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pvt_gpi_filter_if
//  Description : Signal bundle between the private-bus GPI deserializer /
//                register block and the GPI glitch filter.
//                slave  modport : filter side (consumes frame data, drives
//                                 the filtered vector and event status)
//                master modport : deserializer / register side
//  Signals     : clk_ena      - timer tick shared with the deserializer
//                par_load_n   - frame marker (par_load_out_n)
//                par_data_in  - parallel GPI data
//                irq_mask     - 1 = bit excluded from irq
//                evt_clr      - write-1-to-clear strobe for events
//                filt_data    - filtered input vector
//                rise_evt     - sticky 0->1 events
//                fall_evt     - sticky 1->0 events
//                irq          - level interrupt
//                frame_valid  - filt_data holds sampled data
//                stale        - frame markers have stopped arriving
//  Revision    : 1.0 - initial release
// ============================================================================
interface pvt_gpi_filter_if #(
  parameter int TOTAL_BIT_COUNT = 64
);
  logic                       clk_ena;
  logic                       par_load_n;
  logic [TOTAL_BIT_COUNT-1:0] par_data_in;
  logic [TOTAL_BIT_COUNT-1:0] irq_mask;
  logic [TOTAL_BIT_COUNT-1:0] evt_clr;
  logic [TOTAL_BIT_COUNT-1:0] filt_data;
  logic [TOTAL_BIT_COUNT-1:0] rise_evt;
  logic [TOTAL_BIT_COUNT-1:0] fall_evt;
  logic                       irq;
  logic                       frame_valid;
  logic                       stale;

  modport slave (
    input  clk_ena, par_load_n, par_data_in, irq_mask, evt_clr,
    output filt_data, rise_evt, fall_evt, irq, frame_valid, stale
  );

  modport master (
    output clk_ena, par_load_n, par_data_in, irq_mask, evt_clr,
    input  filt_data, rise_evt, fall_evt, irq, frame_valid, stale
  );
endinterface
`default_nettype wire

// File: rtl/pvt_gpi_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pvt_gpi_filter
//  Description : Frame-based glitch filter for the private-bus GPI vector.
//                Each bit must disagree with the filtered value for
//                FILTER_DEPTH consecutive frames before the filtered value
//                follows it. Changes of the filtered vector latch sticky
//                rise/fall events (write-1-to-clear) feeding a maskable
//                level interrupt. A timeout flags a stale bus when frame
//                markers stop arriving.
//  Ports       : clk   - fast clock
//                reset - asynchronous, active-high reset
//                bus   - pvt_gpi_filter_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module pvt_gpi_filter #(
  parameter int                         TOTAL_BIT_COUNT = 64,
  parameter logic [TOTAL_BIT_COUNT-1:0] DEFAULT_STATE   = '0,
  parameter int                         FILTER_DEPTH    = 2,
  parameter int                         FILT_CNT_BITS   = 2,
  parameter int                         TIMEOUT_TICKS   = 200,
  parameter int                         TIMEOUT_BITS    = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pvt_gpi_filter_if.slave bus
);

  localparam logic [FILT_CNT_BITS-1:0] C_DEPTH  = FILT_CNT_BITS'(FILTER_DEPTH);
  localparam logic [FILT_CNT_BITS-1:0] C_CNT_1  = FILT_CNT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0]  C_TO_MAX = TIMEOUT_BITS'(TIMEOUT_TICKS);
  localparam logic [TIMEOUT_BITS-1:0]  C_TO_1   = TIMEOUT_BITS'(1);

  // First boundary after reset closes a partial frame and is discarded;
  // the second one loads the filter directly; afterwards normal filtering.
  typedef enum logic [1:0] {
    ST_DISCARD = 2'd0,
    ST_LOAD    = 2'd1,
    ST_FILTER  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         w_load;
  logic                         w_filt_en;

  logic                         r_pl_prev;
  logic                         w_boundary;

  logic [TOTAL_BIT_COUNT-1:0]   r_filt;
  logic [TOTAL_BIT_COUNT-1:0]   w_filt_nxt;
  logic [FILT_CNT_BITS-1:0]     r_cnt     [TOTAL_BIT_COUNT];
  logic [FILT_CNT_BITS-1:0]     w_cnt_nxt [TOTAL_BIT_COUNT];
  logic [TOTAL_BIT_COUNT-1:0]   w_rise_set;
  logic [TOTAL_BIT_COUNT-1:0]   w_fall_set;
  logic [TOTAL_BIT_COUNT-1:0]   r_rise;
  logic [TOTAL_BIT_COUNT-1:0]   r_fall;
  logic                         r_irq;

  logic [TIMEOUT_BITS-1:0]      r_to_cnt;
  logic [TIMEOUT_BITS-1:0]      w_to_inc;
  logic                         r_stale;

  // A boundary is the falling edge of the frame marker. The history register
  // resets to 0, so a marker already low out of reset does not count.
  assign w_boundary = !bus.par_load_n && r_pl_prev;
  assign w_to_inc   = r_to_cnt + C_TO_1;

  // --------------------------------------------------------------------------
  // Frame sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_DISCARD;
      r_pl_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pl_prev <= bus.par_load_n;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_filt_en   = 1'b0;
    case (r_state)
      ST_DISCARD: begin
        if (w_boundary) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_boundary) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FILTER;
        end
      end
      ST_FILTER: begin
        w_filt_en = w_boundary;
      end
      default: begin
        w_state_nxt = ST_DISCARD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-bit disagreement filter
  // --------------------------------------------------------------------------
  always_comb begin
    w_filt_nxt = r_filt;
    w_rise_set = '0;
    w_fall_set = '0;
    for (int i = 0; i < TOTAL_BIT_COUNT; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end

    if (w_load) begin
      w_filt_nxt = bus.par_data_in;
    end else if (w_filt_en) begin
      for (int i = 0; i < TOTAL_BIT_COUNT; i++) begin
        if (bus.par_data_in[i] == r_filt[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] + C_CNT_1 == C_DEPTH) begin
          w_filt_nxt[i] = bus.par_data_in[i];
          w_cnt_nxt[i]  = '0;
          w_rise_set[i] = bus.par_data_in[i];
          w_fall_set[i] = !bus.par_data_in[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + C_CNT_1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= DEFAULT_STATE;
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
      for (int i = 0; i < TOTAL_BIT_COUNT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_filt <= w_filt_nxt;
      // A new event wins over a coincident clear of the same bit.
      r_rise <= w_rise_set | (r_rise & ~bus.evt_clr);
      r_fall <= w_fall_set | (r_fall & ~bus.evt_clr);
      r_irq  <= |((r_rise | r_fall) & ~bus.irq_mask);
      for (int i = 0; i < TOTAL_BIT_COUNT; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stale-bus timeout; a boundary takes priority over a coincident tick
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_boundary) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (bus.clk_ena && (r_to_cnt != C_TO_MAX)) begin
      r_to_cnt <= w_to_inc;
      if (w_to_inc == C_TO_MAX) r_stale <= 1'b1;
    end
  end

  assign bus.filt_data   = r_filt;
  assign bus.rise_evt    = r_rise;
  assign bus.fall_evt    = r_fall;
  assign bus.irq         = r_irq;
  assign bus.frame_valid = (r_state == ST_FILTER);
  assign bus.stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_pvt_gpi_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pvt_gpi_filter
//  Description : Directed self-checking bench for pvt_gpi_filter with
//                hand-computed expected values (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pvt_gpi_filter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pvt_gpi_filter_if #(.TOTAL_BIT_COUNT(64)) bus ();

  pvt_gpi_filter #(
    .TOTAL_BIT_COUNT (64),
    .DEFAULT_STATE   (64'h0),
    .FILTER_DEPTH    (2),
    .FILT_CNT_BITS   (2),
    .TIMEOUT_TICKS   (200),
    .TIMEOUT_BITS    (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: marker high for a cycle, then a boundary cycle carrying data.
  task automatic boundary(input logic [63:0] data, input logic [63:0] clr);
    bus.par_load_n = 1'b1;
    tick();
    bus.par_load_n  = 1'b0;
    bus.par_data_in = data;
    bus.evt_clr     = clr;
    tick();
    bus.evt_clr = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.clk_ena     = 1'b0;
    bus.par_load_n  = 1'b1;
    bus.par_data_in = '0;
    bus.irq_mask    = '0;
    bus.evt_clr     = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_filt",  bus.filt_data,   64'h0);
    check("rst_rise",  bus.rise_evt,    64'h0);
    check("rst_fall",  bus.fall_evt,    64'h0);
    check("rst_irq",   64'(bus.irq),    64'h0);
    check("rst_fv",    64'(bus.frame_valid), 64'h0);
    check("rst_stale", 64'(bus.stale),  64'h0);

    // Discard, load, steady
    boundary(64'hA5, '0);
    check("b1_fv",   64'(bus.frame_valid), 64'h0);
    check("b1_filt", bus.filt_data, 64'h0);
    boundary(64'hA5, '0);
    check("b2_fv",   64'(bus.frame_valid), 64'h1);
    check("b2_filt", bus.filt_data, 64'hA5);
    check("b2_rise", bus.rise_evt,  64'h0);
    boundary(64'hA5, '0);
    check("b3_filt", bus.filt_data, 64'hA5);
    check("b3_rise", bus.rise_evt,  64'h0);
    check("b3_fall", bus.fall_evt,  64'h0);

    // Single-frame glitch on bit 3 is rejected
    boundary(64'hAD, '0);
    check("gl_filt", bus.filt_data, 64'hA5);
    boundary(64'hA5, '0);
    check("gl_filt2", bus.filt_data, 64'hA5);
    check("gl_rise",  bus.rise_evt,  64'h0);

    // Two consecutive frames pass
    boundary(64'hAD, '0);
    check("p1_filt", bus.filt_data, 64'hA5);
    boundary(64'hAD, '0);
    check("p2_filt", bus.filt_data, 64'hAD);
    check("p2_rise", bus.rise_evt,  64'h8);
    check("p2_irq0", 64'(bus.irq),  64'h0);
    tick();
    check("p2_irq1", 64'(bus.irq),  64'h1);

    // Mask, unmask, clear
    bus.irq_mask = 64'h8;
    tick();
    check("mask_irq", 64'(bus.irq), 64'h0);
    bus.irq_mask = '0;
    tick();
    check("unmask_irq", 64'(bus.irq), 64'h1);
    bus.evt_clr = 64'h8;
    tick();
    bus.evt_clr = '0;
    check("clr_rise", bus.rise_evt, 64'h0);
    check("clr_irq_lag", 64'(bus.irq), 64'h1);
    tick();
    check("clr_irq", 64'(bus.irq), 64'h0);

    // Falling change of bit 3 with a coincident clear: set wins
    boundary(64'hA5, '0);
    check("f1_filt", bus.filt_data, 64'hAD);
    boundary(64'hA5, 64'h8);
    check("f2_filt", bus.filt_data, 64'hA5);
    check("f2_fall", bus.fall_evt,  64'h8);
    tick();
    check("f2_irq", 64'(bus.irq), 64'h1);

    // Stale after 200 ticks without a boundary
    bus.clk_ena = 1'b1;
    for (int k = 0; k < 199; k++) tick();
    check("to199_stale", 64'(bus.stale), 64'h0);
    tick();
    check("to200_stale", 64'(bus.stale), 64'h1);
    for (int k = 0; k < 5; k++) tick();
    check("to_hold_stale", 64'(bus.stale), 64'h1);
    check("to_hold_filt",  bus.filt_data,  64'hA5);
    check("to_hold_fv",    64'(bus.frame_valid), 64'h1);
    boundary(64'hA5, '0);
    check("to_clr_stale", 64'(bus.stale), 64'h0);
    bus.clk_ena = 1'b0;

    // Reset mid-filter (bit 5 partially counted), marker low through reset
    boundary(64'h85, '0);
    check("mf_filt", bus.filt_data, 64'hA5);
    reset = 1'b1;
    #1;
    check("ar_filt", bus.filt_data, 64'h0);
    check("ar_fall", bus.fall_evt,  64'h0);
    check("ar_fv",   64'(bus.frame_valid), 64'h0);
    check("ar_irq",  64'(bus.irq),  64'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("low_fv", 64'(bus.frame_valid), 64'h0);
    boundary(64'h85, '0);
    check("rb1_fv",   64'(bus.frame_valid), 64'h0);
    check("rb1_filt", bus.filt_data, 64'h0);
    boundary(64'h85, '0);
    check("rb2_fv",   64'(bus.frame_valid), 64'h1);
    check("rb2_filt", bus.filt_data, 64'h85);
    check("rb2_rise", bus.rise_evt,  64'h0);
    check("rb2_fall", bus.fall_evt,  64'h0);
    boundary(64'hA5, '0);
    check("rb3_filt", bus.filt_data, 64'h85);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
